// File: rtl/lms_error_calc.sv
// LMS prediction/error stage: y_hat = a*x[n-1] + b*y[n-1], e = y[n] - y_hat, both saturated.
// Five-state pipeline, one sample per 5 clocks; flag_e_out 3 edges after acceptance; sample_valid ignored while busy.
module lms_error_calc #(
   parameter int                 FRAC   = 0,
   parameter logic signed [7:0]  X_INIT = 8'sd0,
   parameter logic signed [7:0]  Y_INIT = 8'sd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic signed [7:0] x_in,
   input  logic signed [7:0] y_in,
   input  logic signed [7:0] a_hat,
   input  logic signed [7:0] b_hat,
   output logic              sample_ready,
   output logic signed [7:0] x_last,
   output logic signed [7:0] y_last,
   output logic signed [7:0] y_hat,
   output logic signed [7:0] e_current,
   output logic              flag_e_out
);

   typedef enum logic [2:0] {IDLE, MUL, ACC, ERR, OUT} state_t;

   state_t state, state_nx;

   logic signed [7:0]  x_s, y_s, a_s, b_s;
   logic signed [15:0] pa, pb;
   logic signed [15:0] a_ext, b_ext, xl_ext, yl_ext;
   logic signed [16:0] sum, sum_sh;
   logic signed [8:0]  diff;
   logic signed [7:0]  yhat_sat, err_sat;
   logic               accept;

   assign accept = (state == IDLE) && sample_valid && sample_ready;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = MUL;
         MUL:     state_nx = ACC;
         ACC:     state_nx = ERR;
         ERR:     state_nx = OUT;
         OUT:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Sign-extend before multiplying so the full 16-bit product is formed.
   always_comb begin
      a_ext  = {{8{a_s[7]}}, a_s};
      b_ext  = {{8{b_s[7]}}, b_s};
      xl_ext = {{8{x_last[7]}}, x_last};
      yl_ext = {{8{y_last[7]}}, y_last};
      sum    = {pa[15], pa} + {pb[15], pb};
      sum_sh = sum >>> FRAC;
      if (sum_sh > 17'sd127)
         yhat_sat = 8'sd127;
      else if (sum_sh < -17'sd128)
         yhat_sat = -8'sd128;
      else
         yhat_sat = sum_sh[7:0];
      diff = {y_s[7], y_s} - {y_hat[7], y_hat};
      if (diff > 9'sd127)
         err_sat = 8'sd127;
      else if (diff < -9'sd128)
         err_sat = -8'sd128;
      else
         err_sat = diff[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         sample_ready <= 1'b0;
         flag_e_out   <= 1'b0;
         x_last       <= X_INIT;
         y_last       <= Y_INIT;
         y_hat        <= '0;
         e_current    <= '0;
         x_s          <= '0;
         y_s          <= '0;
         a_s          <= '0;
         b_s          <= '0;
         pa           <= '0;
         pb           <= '0;
      end else begin
         state        <= state_nx;
         sample_ready <= (state_nx == IDLE);
         flag_e_out   <= (state == ERR);
         case (state)
            IDLE: if (accept) begin
               x_s <= x_in;
               y_s <= y_in;
               a_s <= a_hat;
               b_s <= b_hat;
            end
            MUL: begin
               pa <= a_ext * xl_ext;
               pb <= b_ext * yl_ext;
            end
            ACC: y_hat     <= yhat_sat;
            ERR: e_current <= err_sat;
            OUT: begin
               x_last <= x_s;
               y_last <= y_s;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lms_error_calc.sv
// Drives two instances (FRAC=0 default init, FRAC=2 non-zero init) and compares against an arithmetic model.
module tb_lms_error_calc;

   logic              clk = 1'b0;
   logic              rst;
   logic              sample_valid;
   logic signed [7:0] x_in, y_in, a_hat, b_hat;

   logic              ready_o [2];
   logic signed [7:0] xl_o [2];
   logic signed [7:0] yl_o [2];
   logic signed [7:0] yh_o [2];
   logic signed [7:0] e_o  [2];
   logic              flag_o [2];

   int checks = 0;
   int errors = 0;
   int mxl [2];
   int myl [2];

   always #5 clk = ~clk;

   lms_error_calc #(.FRAC(0)) dut0 (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .x_in(x_in), .y_in(y_in), .a_hat(a_hat), .b_hat(b_hat),
      .sample_ready(ready_o[0]), .x_last(xl_o[0]), .y_last(yl_o[0]),
      .y_hat(yh_o[0]), .e_current(e_o[0]), .flag_e_out(flag_o[0])
   );

   lms_error_calc #(.FRAC(2), .X_INIT(8'sd3), .Y_INIT(-8'sd2)) dut2 (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .x_in(x_in), .y_in(y_in), .a_hat(a_hat), .b_hat(b_hat),
      .sample_ready(ready_o[1]), .x_last(xl_o[1]), .y_last(yl_o[1]),
      .y_hat(yh_o[1]), .e_current(e_o[1]), .flag_e_out(flag_o[1])
   );

   function automatic int sat8(input int v);
      return (v > 127) ? 127 : ((v < -128) ? -128 : v);
   endfunction

   function automatic int frac_of(input int k);
      return (k == 0) ? 0 : 2;
   endfunction

   function automatic int init_x(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   function automatic int init_y(input int k);
      return (k == 0) ? 0 : -2;
   endfunction

   function automatic int rnd8();
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mxl[k] = init_x(k);
         myl[k] = init_y(k);
      end
   endtask

   task automatic noise(input bit noisy);
      if (noisy) begin
         sample_valid = ($urandom_range(0, 1) == 1);
         x_in  = 8'(rnd8());
         y_in  = 8'(rnd8());
         a_hat = 8'(rnd8());
         b_hat = 8'(rnd8());
      end else begin
         sample_valid = 1'b0;
      end
   endtask

   task automatic do_sample(input int x, input int y, input int a, input int b, input bit noisy);
      int yh [2];
      int ee [2];
      int waited;
      waited = 0;
      @(negedge clk);
      while (!ready_o[0] && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_before0", int'(ready_o[0]), 1);
      chk("ready_before2", int'(ready_o[1]), 1);
      sample_valid = 1'b1;
      x_in  = 8'(x);
      y_in  = 8'(y);
      a_hat = 8'(a);
      b_hat = 8'(b);
      for (int k = 0; k < 2; k++) begin
         yh[k] = sat8((a * mxl[k] + b * myl[k]) >>> frac_of(k));
         ee[k] = sat8(y - yh[k]);
      end
      @(negedge clk);
      noise(noisy);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("busy_ready%0d", k), int'(ready_o[k]), 0);
         chk($sformatf("flag_e1_%0d", k), int'(flag_o[k]), 0);
      end
      @(negedge clk);
      noise(noisy);
      for (int k = 0; k < 2; k++) chk($sformatf("flag_e2_%0d", k), int'(flag_o[k]), 0);
      @(negedge clk);
      noise(noisy);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("yhat_e2_%0d", k), int'(yh_o[k]), yh[k]);
         chk($sformatf("flag_e3pre_%0d", k), int'(flag_o[k]), 0);
      end
      @(negedge clk);
      noise(noisy);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("flag_hi%0d", k), int'(flag_o[k]), 1);
         chk($sformatf("yhat%0d", k), int'(yh_o[k]), yh[k]);
         chk($sformatf("err%0d", k), int'(e_o[k]), ee[k]);
         chk($sformatf("xlast_old%0d", k), int'(xl_o[k]), mxl[k]);
         chk($sformatf("ylast_old%0d", k), int'(yl_o[k]), myl[k]);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mxl[k] = x;
         myl[k] = y;
         chk($sformatf("flag_lo%0d", k), int'(flag_o[k]), 0);
         chk($sformatf("xlast_new%0d", k), int'(xl_o[k]), mxl[k]);
         chk($sformatf("ylast_new%0d", k), int'(yl_o[k]), myl[k]);
         chk($sformatf("ready_after%0d", k), int'(ready_o[k]), 1);
         chk($sformatf("err_hold%0d", k), int'(e_o[k]), ee[k]);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_ready%0d", tag, k), int'(ready_o[k]), 0);
         chk($sformatf("%s_flag%0d", tag, k), int'(flag_o[k]), 0);
         chk($sformatf("%s_yhat%0d", tag, k), int'(yh_o[k]), 0);
         chk($sformatf("%s_err%0d", tag, k), int'(e_o[k]), 0);
         chk($sformatf("%s_xlast%0d", tag, k), int'(xl_o[k]), init_x(k));
         chk($sformatf("%s_ylast%0d", tag, k), int'(yl_o[k]), init_y(k));
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      sample_valid = 1'b1;
      x_in = 8'(rnd8()); y_in = 8'(rnd8());
      a_hat = 8'(rnd8()); b_hat = 8'(rnd8());
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst_hold");

      sample_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rel_ready_imm", int'(ready_o[0]), 0);
      @(negedge clk);
      chk("rel_ready0", int'(ready_o[0]), 1);
      chk("rel_ready2", int'(ready_o[1]), 1);
      chk("rel_flag0", int'(flag_o[0]), 0);

      // Directed samples
      do_sample(5, 10, 2, 1, 1'b0);
      do_sample(3, 30, 2, 1, 1'b1);
      do_sample(127, 127, 0, 0, 1'b0);
      do_sample(0, -128, 127, 127, 1'b1);
      do_sample(-128, -128, 0, 0, 1'b0);
      do_sample(0, 127, -128, -128, 1'b1);
      do_sample(5, 0, 0, 0, 1'b0);
      do_sample(0, 0, -3, 0, 1'b0);

      for (int i = 0; i < 20; i++)
         do_sample(rnd8(), rnd8(), rnd8(), rnd8(), (i % 2) == 1);

      // Abort while in ACC
      @(negedge clk);
      sample_valid = 1'b1;
      x_in = 8'sd40; y_in = 8'sd50; a_hat = 8'sd7; b_hat = 8'sd9;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_outputs("abort");
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("abort_noflag0", int'(flag_o[0]), 0);
         chk("abort_noflag2", int'(flag_o[1]), 0);
      end
      do_sample(11, -20, 3, -4, 1'b0);
      do_sample(-7, 90, -2, 5, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lms_error_calc.md
Name: lms_error_calc

Overview:
- Upstream neighbour of the LMS coefficient-update stage.
- Keeps the one-sample regressor registers (x_last, y_last) and forms the prediction y_hat = a_hat*x_last + b_hat*y_last from the current coefficients.
- Produces the saturated error e_current = y_in - y_hat with a one-cycle flag_e_out strobe.
- The update stage consumes e_current, x_last and y_last while flag_e_out is high.

Parameters:
- FRAC, 0: arithmetic right-shift applied to the product sum (fixed-point fraction bits of a_hat/b_hat); legal 0..7.
- X_INIT, 8'sd0: reset value of x_last.
- Y_INIT, 8'sd0: reset value of y_last.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- sample_valid  in  1  new sample pair offered.
- x_in  in  8 signed  plant input sample x[n].
- y_in  in  8 signed  plant output sample y[n] (desired response).
- a_hat  in  8 signed  current coefficient for x_last.
- b_hat  in  8 signed  current coefficient for y_last.
- sample_ready  out  1  high only in IDLE and when not in reset.
- x_last  out  8 signed  regressor x[n-1].
- y_last  out  8 signed  regressor y[n-1].
- y_hat  out  8 signed  registered saturated prediction.
- e_current  out  8 signed  registered saturated error.
- flag_e_out  out  1  one-cycle strobe: e_current valid, paired with current x_last/y_last.

Behaviour:
- Reset (rst low, async): state=IDLE; x_last=X_INIT, y_last=Y_INIT; y_hat=0; e_current=0; flag_e_out=0; sample_ready=0; internal sample/product registers=0.
- FSM, one transition per posedge:
  - IDLE: if sample_valid && sample_ready, latch x_in, y_in, a_hat, b_hat, then go to MUL. Otherwise stay.
  - MUL: pa = a_s*x_last and pb = b_s*y_last (16-bit signed, registered), then go to ACC.
  - ACC: s = (pa+pb) as 17-bit signed; s >>> FRAC (arithmetic, floor); saturate to [-128,127]; register into y_hat; go to ERR.
  - ERR: d = y_s - y_hat as 9-bit signed; saturate to [-128,127]; register into e_current; set flag_e_out=1; go to OUT.
  - OUT: flag_e_out=0; x_last<=x_s; y_last<=y_s; go to IDLE.
- Timing:
  - Acceptance edge E0. flag_e_out is high between E3 and E4. x_last/y_last change at E4. sample_ready is high again after E4.
  - Throughput is 1 sample per 5 clocks.
- Handshake:
  - sample_valid outside IDLE is ignored and not queued.
  - Coefficients are sampled only at E0. Changes to a_hat/b_hat mid-computation have no effect.
- Update-stage pairing:
  - x_last, y_last and e_current are stable for the whole cycle flag_e_out is high.
  - The update stage's negedge sample inside that cycle therefore sees a consistent triple.
  - e_current and y_hat hold their values until the next ERR/ACC.
- Saturation applies at both points: y_hat and e_current. No wrap-around is permitted anywhere.
- Reset mid-operation: the FSM aborts immediately and every output takes its reset value. No flag_e_out is produced for the aborted sample, and it is not retried.
- Simultaneous events: sample_valid arriving on the same edge as the OUT->IDLE transition is not accepted, because sample_ready is still low in OUT. It is accepted on the following edge if it is still held.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0 (x_last=X_INIT, y_last=Y_INIT), sample_ready=0. Release rst -> sample_ready=1 on the next cycle, flag_e_out=0.
- First sample, FRAC=0, a_hat=2, b_hat=1, x_in=5, y_in=10 -> y_hat=0, e_current=10. flag_e_out high exactly one cycle, 3 edges after acceptance. Then x_last=5, y_last=10.
- Second sample, a_hat=2, b_hat=1, x_in=3, y_in=30 -> y_hat=2*5+1*10=20, e_current=10. After OUT: x_last=3, y_last=30.
- Saturation: x_last=y_last=127, a_hat=b_hat=127, y_in=-128 -> y_hat=127, e_current=-128 (not wrapped). Repeat with all values at -128 and y_in=127 -> y_hat=127, e_current=0.
- FRAC=2, a_hat=-3, x_last=5, b_hat=0, y_in=0 -> y_hat=-4 (floor of -15/4), e_current=4.
- Busy/abort: pulse sample_valid during MUL/ACC/ERR/OUT -> ignored, one flag only. Assert rst=0 during ACC -> no flag_e_out, outputs reset, and the next accepted sample completes normally.
